// File: rtl/sram_arb_pkg.sv
// Shared IDs, access-size encodings and grant-state type for the SRAM bus arbiter.
package sram_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } gnt_state_t;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order owner-ID queue: one bit per accepted-but-unreturned memory transaction.
module arb_id_fifo
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

    logic [MAX_OUT-1:0] ids;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [2:0]         count;
    logic               do_push;
    logic               do_pop;

    // Pointers wrap explicitly so non-power-of-two depths behave as a true ring.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // full ignores a same-cycle pop: a returning response never frees a slot early.
    assign full    = (count == 3'(MAX_OUT));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = ids[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ids    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                ids[wr_ptr] <= push_id;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and memory (data) stages,
// routing each in-order response back to the requester that issued it.
module sram_bus_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic        err
);

    gnt_state_t state;
    logic       gnt_valid;
    logic       gnt_id;
    logic       win_req;
    logic       q_full;
    logic       q_empty;
    logic       q_head;
    logic       handshake;

    // A stalled request stays locked to its owner so the downstream fields hold.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ID_INST;
        case (state)
            LOCK_I: begin
                gnt_valid = 1'b1;
                gnt_id    = ID_INST;
            end
            LOCK_D: begin
                gnt_valid = 1'b1;
                gnt_id    = ID_DATA;
            end
            default: begin
                if (!q_full) begin
                    if (data_req) begin
                        gnt_valid = 1'b1;
                        gnt_id    = ID_DATA;
                    end else if (inst_req) begin
                        gnt_valid = 1'b1;
                        gnt_id    = ID_INST;
                    end
                end
            end
        endcase
    end

    assign win_req   = gnt_valid & ((gnt_id == ID_DATA) ? data_req : inst_req);
    assign mem_req   = win_req & ~q_full;
    assign handshake = mem_req & mem_addr_ok;

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_valid) begin
            if (gnt_id == ID_DATA) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end
    end

    assign inst_addr_ok = handshake & (gnt_id == ID_INST);
    assign data_addr_ok = handshake & (gnt_id == ID_DATA);

    assign inst_data_ok = mem_data_ok & ~q_empty & (q_head == ID_INST);
    assign data_data_ok = mem_data_ok & ~q_empty & (q_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            if (mem_data_ok && q_empty) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (win_req && !mem_addr_ok) begin
                        state <= (gnt_id == ID_DATA) ? LOCK_D : LOCK_I;
                    end
                end
                LOCK_I: begin
                    if (!inst_req || handshake) begin
                        state <= IDLE;
                    end
                end
                LOCK_D: begin
                    if (!data_req || handshake) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    arb_id_fifo #(
        .MAX_OUT(MAX_OUT)
    ) u_id_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (handshake),
        .push_id(gnt_id),
        .pop    (mem_data_ok),
        .full   (q_full),
        .empty  (q_empty),
        .head   (q_head)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Vector-table bench for sram_bus_arbiter with an owner-ID scoreboard for responses.
module tb_sram_bus_arbiter;
    import sram_arb_pkg::*;

    localparam logic [31:0] IADDR  = 32'h1c00_0000;
    localparam logic [31:0] DADDR  = 32'h8000_1000;
    localparam logic [31:0] IWDATA = 32'h1111_2222;
    localparam logic [31:0] DWDATA = 32'hdead_beef;
    localparam int NV = 25;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        err;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUT(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(1'b0), .inst_size(SZ_WORD), .inst_wstrb(4'h0),
        .inst_addr(IADDR), .inst_wdata(IWDATA),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(1'b1), .data_size(SZ_WORD), .data_wstrb(4'hF),
        .data_addr(DADDR), .data_wdata(DWDATA),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .err(err)
    );

    // gnt: 0 = nothing granted, 1 = inst, 2 = data
    typedef struct {
        logic       rst;
        logic       ir;
        logic       dr;
        logic       mao;
        logic       mdo;
        logic       mreq;
        logic [1:0] gnt;
        logic       iaok;
        logic       daok;
    } vec_t;

    vec_t vecs [NV];
    bit   sb_q [$];
    bit   sb_err;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, e_addr, e_wdata;
        logic        e_wr, e_idok, e_ddok;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_size;

        //            rst ir dr mao mdo mreq gnt iaok daok
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};   // reset state
        vecs[1]  = '{0, 1, 0, 1, 0, 1, 1, 1, 0};   // inst read accepted
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};   // inst response
        vecs[4]  = '{0, 1, 1, 1, 0, 1, 2, 0, 1};   // data wins
        vecs[5]  = '{0, 1, 0, 1, 0, 1, 1, 1, 0};   // inst follows, queue now full
        vecs[6]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0};   // full: no grant
        vecs[7]  = '{0, 1, 0, 1, 1, 0, 0, 0, 0};   // pop same cycle still blocks
        vecs[8]  = '{0, 1, 0, 1, 0, 1, 1, 1, 0};   // accepted next cycle
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 1, 1, 0, 0};   // inst stalls -> lock
        vecs[12] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};   // lock holds against data
        vecs[13] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};   // inst accepted
        vecs[14] = '{0, 0, 1, 1, 0, 1, 2, 0, 1};   // data granted next
        vecs[15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 1, 0, 0, 1, 2, 0, 0};   // data stalls -> lock
        vecs[18] = '{0, 1, 0, 1, 0, 0, 2, 0, 0};   // locked requester drops req
        vecs[19] = '{0, 1, 0, 1, 0, 1, 1, 1, 0};   // one outstanding
        vecs[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};   // reset mid-flight
        vecs[21] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};   // late response -> err
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[23] = '{0, 1, 1, 1, 0, 1, 2, 0, 1};
        vecs[24] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        reset = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        sb_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (vecs[i].rst) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                sb_q.delete();
                sb_err = 1'b0;
            end
            rd = 32'h0280_0c0c ^ (32'(i) << 12);
            inst_req    = vecs[i].ir;
            data_req    = vecs[i].dr;
            mem_addr_ok = vecs[i].mao;
            mem_data_ok = vecs[i].mdo;
            mem_rdata   = rd;
            #1;

            e_addr  = (vecs[i].gnt == 2'd1) ? IADDR  : (vecs[i].gnt == 2'd2) ? DADDR  : 32'h0;
            e_wdata = (vecs[i].gnt == 2'd1) ? IWDATA : (vecs[i].gnt == 2'd2) ? DWDATA : 32'h0;
            e_wr    = (vecs[i].gnt == 2'd2);
            e_wstrb = (vecs[i].gnt == 2'd2) ? 4'hF : 4'h0;
            e_size  = (vecs[i].gnt == 2'd0) ? 2'd0 : SZ_WORD;
            e_idok  = vecs[i].mdo && sb_q.size() > 0 && sb_q[0] == ID_INST;
            e_ddok  = vecs[i].mdo && sb_q.size() > 0 && sb_q[0] == ID_DATA;

            check($sformatf("v%0d mem_req", i),      32'(mem_req),      32'(vecs[i].mreq));
            check($sformatf("v%0d inst_addr_ok", i), 32'(inst_addr_ok), 32'(vecs[i].iaok));
            check($sformatf("v%0d data_addr_ok", i), 32'(data_addr_ok), 32'(vecs[i].daok));
            check($sformatf("v%0d mem_addr", i),     mem_addr,          e_addr);
            check($sformatf("v%0d mem_wdata", i),    mem_wdata,         e_wdata);
            check($sformatf("v%0d mem_wr", i),       32'(mem_wr),       32'(e_wr));
            check($sformatf("v%0d mem_wstrb", i),    32'(mem_wstrb),    32'(e_wstrb));
            check($sformatf("v%0d mem_size", i),     32'(mem_size),     32'(e_size));
            check($sformatf("v%0d inst_data_ok", i), 32'(inst_data_ok), 32'(e_idok));
            check($sformatf("v%0d data_data_ok", i), 32'(data_data_ok), 32'(e_ddok));
            check($sformatf("v%0d inst_rdata", i),   inst_rdata,        rd);
            check($sformatf("v%0d data_rdata", i),   data_rdata,        rd);
            check($sformatf("v%0d err", i),          32'(err),          32'(sb_err));

            if (vecs[i].mdo) begin
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                else sb_err = 1'b1;
            end
            if (vecs[i].iaok) sb_q.push_back(ID_INST);
            if (vecs[i].daok) sb_q.push_back(ID_DATA);
        end

        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        #1;
        check("final err sticky", 32'(err), 32'(sb_err));
        check("final queue drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the fetch stage (instruction requester) and the memory stage (data requester). Each requester uses a req/addr_ok/data_ok handshake, and the block forwards the winner to the downstream port. It records the owner of every accepted transaction in a small in-order ID queue and routes each returned data_ok/rdata back to that owner. The block sits between the pipeline stages and the memory bridge.

## Interface
- MAX_OUT, 2: maximum accepted-but-unreturned transactions; legal range 1–4.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req / data_req  in  1  request valid.
- inst_wr / data_wr  in  1  1 = write.
- inst_size / data_size  in  2  access size: 0 = byte, 1 = half, 2 = word.
- inst_wstrb / data_wstrb  in  4  byte write enables.
- inst_addr / data_addr  in  32  byte address.
- inst_wdata / data_wdata  in  32  write data.
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
- inst_data_ok / data_data_ok  out  1  response for this requester this cycle.
- inst_rdata / data_rdata  out  32  read data; always equals mem_rdata.
- mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/1/2/4/32/32  downstream request fields.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response valid; responses return in request order.
- mem_rdata  in  32  downstream read data.
- err  out  1  sticky flag: a response arrived while the ID queue was empty.

## Operation
- Address handshake for a requester = its req & its addr_ok in the same cycle.
- Grant FSM states:
  - IDLE: if the queue is full, no grant.
  - IDLE, queue not full: data_req wins over inst_req.
  - IDLE, winner asserted but mem_addr_ok = 0: next state is LOCK_I or LOCK_D for that winner.
  - LOCK_I / LOCK_D: grant stays on the locked requester regardless of the other req.
  - LOCK_x, handshake completes: next state IDLE.
  - LOCK_x, locked requester drops req: next state IDLE (protocol violation, no transfer).
- Forwarding:
  - mem_req = granted requester's req & queue not full.
  - Other mem_* fields are muxed from the granted requester; they are all-zero when nothing is granted.
  - Only the granted requester sees addr_ok = mem_addr_ok & mem_req; the other requester's addr_ok = 0.
- ID queue:
  - FIFO of MAX_OUT 1-bit entries (0 = inst, 1 = data).
  - Push the granted ID on every downstream handshake (mem_req & mem_addr_ok).
  - Pop on mem_data_ok when not empty.
  - full = (count == MAX_OUT), evaluated before any same-cycle pop; a same-cycle pop does not free a slot for a push.
- Response routing:
  - mem_data_ok with queue not empty: assert data_ok to the head ID only.
  - mem_data_ok with queue empty: both data_ok = 0, err set to 1.
- Counters:
  - count is 3 bits; pointers are log2(MAX_OUT) bits and wrap modulo MAX_OUT.
  - Same-cycle push and pop leaves count unchanged.

## Timing
- Zero added latency:
  - req to mem_req is combinational.
  - mem_addr_ok to the requester's addr_ok is combinational.
  - mem_data_ok to the requester's data_ok is combinational, same cycle.
- FSM, queue and err update on the rising clk edge.
- Reset values:
  - FSM = IDLE, count = 0, pointers = 0, err = 0.
  - mem_req = 0, both addr_ok = 0, both data_ok = 0 (assuming no mem_data_ok).
  - rdata outputs follow mem_rdata.
- Reset asserted mid-operation: outstanding entries are discarded immediately (asynchronously). A late mem_data_ok after reset releases sets err.
- Lock behaviour: a stalled request keeps mem_addr and the other mem_* fields stable until accepted, even if the other requester asserts req.

## Structure
- Package sram_arb_pkg:
  - ID_INST = 1'b0, ID_DATA = 1'b1.
  - Size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - Grant-state enum: IDLE, LOCK_I, LOCK_D.
- Sub-module arb_id_fifo: parameterised MAX_OUT depth, 1-bit data, push/pop/full/empty/head outputs, async active-high reset.
- Top level holds the grant FSM, request mux and response demux.

## Test plan
- Inst read: inst_req, addr 0x1c000000, mem_addr_ok = 1 → mem_addr = 0x1c000000 and inst_addr_ok = 1 same cycle; mem_data_ok two cycles later with rdata 0x02800c0c → inst_data_ok = 1, inst_rdata = 0x02800c0c, data_data_ok = 0.
- Simultaneous requests, mem_addr_ok = 1: first cycle data_addr_ok = 1 and inst_addr_ok = 0; next cycle inst handshake completes; count = 2.
- Lock: inst_req alone with mem_addr_ok = 0 for 3 cycles, data_req rises in cycle 1 → mem_addr stays at the inst address until acceptance in cycle 3; data is granted in cycle 4.
- Full queue, MAX_OUT = 2: two accepted transactions, third request → mem_req = 0. mem_data_ok in the same cycle still blocks that cycle; the request is accepted the following cycle.
- Ordering: data write (wstrb 0xF, wdata 0xdeadbeef) accepted, then inst read accepted; two mem_data_ok pulses → first raises data_data_ok, second raises inst_data_ok.
- Reset mid-flight: one outstanding, reset pulse → count = 0, err = 0; a subsequent mem_data_ok → no data_ok on either requester, err = 1.
